// File: rtl/adc_cap_acq.sv
`default_nettype none
// ============================================================================
// Module   : adc_cap_acq
// Purpose  : Acquisition sequencer for the capacitor-voltage path. Drives a
//            multiplexed 14-bit parallel ADC over three channels (resonant
//            cap 1, resonant cap 2, support cap). It averages 2^AVG_LOG2
//            conversions per channel and publishes one settled code per
//            channel.
// Ports    : sys_clk, sys_rst_n       clock, async active-low reset
//            adc_busy, adc_db[13:0]   ADC status and parallel data
//            adc_convst, adc_cs_n,
//            adc_rd_n                 ADC conversion / read strobes
//            mux_sel[1:0]             analog mux select (0..2)
//            adc_data_cap_1..3[13:0]  averaged codes per channel
//            adc_data_valid           1-cycle pulse at end of a 3-channel round
//            adc_timeout_err          sticky busy-timeout flag
// Revision : 1.0  initial release
// ============================================================================
module adc_cap_acq #(
    parameter int SETTLE_CYC   = 50,
    parameter int AVG_LOG2     = 3,
    parameter int BUSY_TIMEOUT = 200
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        adc_busy,
    input  logic [13:0] adc_db,
    output logic        adc_convst,
    output logic        adc_cs_n,
    output logic        adc_rd_n,
    output logic [1:0]  mux_sel,
    output logic [13:0] adc_data_cap_1,
    output logic [13:0] adc_data_cap_2,
    output logic [13:0] adc_data_cap_3,
    output logic        adc_data_valid,
    output logic        adc_timeout_err
);

    localparam int ACC_W   = 14 + AVG_LOG2;
    localparam int NS_W    = AVG_LOG2 + 1;
    localparam int CNT_MAX = (SETTLE_CYC > BUSY_TIMEOUT) ? SETTLE_CYC : BUSY_TIMEOUT;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] C_SETTLE_LAST = CNT_W'(SETTLE_CYC);
    localparam logic [CNT_W-1:0] C_BUSY_LAST   = CNT_W'(BUSY_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_ONE         = CNT_W'(1);
    localparam logic [NS_W-1:0]  C_LAST_SAMPLE = NS_W'((1 << AVG_LOG2) - 1);
    localparam logic [1:0]       C_CH_LAST     = 2'd2;

    localparam logic [2:0] ST_SETTLE    = 3'd0;
    localparam logic [2:0] ST_CONV      = 3'd1;
    localparam logic [2:0] ST_WAIT_BUSY = 3'd2;
    localparam logic [2:0] ST_READ      = 3'd3;
    localparam logic [2:0] ST_ACC       = 3'd4;
    localparam logic [2:0] ST_TIMEOUT   = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [NS_W-1:0]  nsamp_q, nsamp_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [13:0]      sample_q, sample_d;
    logic [1:0]       mux_q, mux_d;
    logic [13:0]      cap1_q, cap1_d;
    logic [13:0]      cap2_q, cap2_d;
    logic [13:0]      cap3_q, cap3_d;
    logic             valid_q, valid_d;
    logic             timeout_err_q, timeout_err_d;

    logic [ACC_W-1:0] w_sum;
    logic [13:0]      w_avg;
    logic [1:0]       w_mux_next;
    logic             w_enter_timeout;

    // Full-scale sum (16383 * 2^AVG_LOG2) fits ACC_W exactly, so no wrap.
    assign w_sum           = acc_q + ACC_W'(sample_q);
    assign w_avg           = w_sum[ACC_W-1:AVG_LOG2];
    assign w_mux_next      = (mux_q == C_CH_LAST) ? 2'd0 : mux_q + 2'd1;
    assign w_enter_timeout = (state_q == ST_WAIT_BUSY) && (state_d == ST_TIMEOUT);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q       <= ST_SETTLE;
            cnt_q         <= '0;
            nsamp_q       <= '0;
            acc_q         <= '0;
            sample_q      <= '0;
            mux_q         <= 2'd0;
            cap1_q        <= '0;
            cap2_q        <= '0;
            cap3_q        <= '0;
            valid_q       <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            nsamp_q       <= nsamp_d;
            acc_q         <= acc_d;
            sample_q      <= sample_d;
            mux_q         <= mux_d;
            cap1_q        <= cap1_d;
            cap2_q        <= cap2_d;
            cap3_q        <= cap3_d;
            valid_q       <= valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic. cnt_q counts cycles spent in the current state.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + C_ONE;
        case (state_q)
            // The entry cycle is the one in which the mux moved; SETTLE_CYC
            // full settled cycles follow it before the first conversion.
            ST_SETTLE: begin
                if (cnt_q == C_SETTLE_LAST) begin
                    state_d = ST_CONV;
                    cnt_d   = '0;
                end
            end
            ST_CONV: begin
                if (cnt_q == C_ONE) begin
                    state_d = ST_WAIT_BUSY;
                    cnt_d   = '0;
                end
            end
            // A low busy wins over a timeout in the same cycle; the first
            // cycle is always spent waiting so busy has time to assert.
            ST_WAIT_BUSY: begin
                if (!adc_busy && (cnt_q >= C_ONE)) begin
                    state_d = ST_READ;
                    cnt_d   = '0;
                end else if (cnt_q == C_BUSY_LAST) begin
                    state_d = ST_TIMEOUT;
                    cnt_d   = '0;
                end
            end
            ST_READ: begin
                if (cnt_q == C_ONE) begin
                    state_d = ST_ACC;
                    cnt_d   = '0;
                end
            end
            ST_ACC: begin
                cnt_d   = '0;
                state_d = (nsamp_q == C_LAST_SAMPLE) ? ST_SETTLE : ST_CONV;
            end
            ST_TIMEOUT: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_SETTLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: sample capture, accumulation, publish and channel advance
    // ------------------------------------------------------------------------
    always_comb begin
        acc_d         = acc_q;
        nsamp_d       = nsamp_q;
        sample_d      = sample_q;
        mux_d         = mux_q;
        cap1_d        = cap1_q;
        cap2_d        = cap2_q;
        cap3_d        = cap3_q;
        valid_d       = 1'b0;
        timeout_err_d = timeout_err_q | w_enter_timeout;
        case (state_q)
            ST_READ: begin
                // Data is taken on the edge that closes the second strobe cycle.
                if (cnt_q == C_ONE) begin
                    sample_d = adc_db;
                end
            end
            ST_ACC: begin
                if (nsamp_q == C_LAST_SAMPLE) begin
                    acc_d   = '0;
                    nsamp_d = '0;
                    mux_d   = w_mux_next;
                    valid_d = (mux_q == C_CH_LAST);
                    case (mux_q)
                        2'd0:    cap1_d = w_avg;
                        2'd1:    cap2_d = w_avg;
                        default: cap3_d = w_avg;
                    endcase
                end else begin
                    acc_d   = w_sum;
                    nsamp_d = nsamp_q + NS_W'(1);
                end
            end
            // Partial channel is dropped; its published code is left alone.
            ST_TIMEOUT: begin
                acc_d   = '0;
                nsamp_d = '0;
                mux_d   = w_mux_next;
                valid_d = (mux_q == C_CH_LAST);
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    always_comb begin
        adc_convst      = (state_q == ST_CONV);
        adc_cs_n        = (state_q != ST_READ);
        adc_rd_n        = (state_q != ST_READ);
        mux_sel         = mux_q;
        adc_data_cap_1  = cap1_q;
        adc_data_cap_2  = cap2_q;
        adc_data_cap_3  = cap3_q;
        adc_data_valid  = valid_q;
        adc_timeout_err = timeout_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_cap_acq.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_cap_acq
// Purpose  : Self-checking bench for adc_cap_acq. A behavioural ADC model
//            serves conversions and records, per channel, the codes the DUT
//            reads; expected outputs are the truncated per-round means of
//            those codes.
// Revision : 1.0  initial release
// ============================================================================
module tb_adc_cap_acq;

    localparam int SETTLE_CYC   = 4;
    localparam int AVG_LOG2     = 2;
    localparam int BUSY_TIMEOUT = 16;
    localparam int NSAMP        = 1 << AVG_LOG2;
    // busy held 5 cycles -> 5 WAIT_BUSY cycles; sample = 2 + 5 + 2 + 1
    localparam int SAMPLE_NOM   = 10;
    localparam int CHAN_NOM     = SETTLE_CYC + NSAMP * SAMPLE_NOM + 1;

    logic        sys_clk   = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        adc_busy  = 1'b0;
    logic [13:0] adc_db    = '0;
    logic        adc_convst, adc_cs_n, adc_rd_n;
    logic [1:0]  mux_sel;
    logic [13:0] adc_data_cap_1, adc_data_cap_2, adc_data_cap_3;
    logic        adc_data_valid, adc_timeout_err;

    adc_cap_acq #(
        .SETTLE_CYC  (SETTLE_CYC),
        .AVG_LOG2    (AVG_LOG2),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .sys_clk        (sys_clk),
        .sys_rst_n      (sys_rst_n),
        .adc_busy       (adc_busy),
        .adc_db         (adc_db),
        .adc_convst     (adc_convst),
        .adc_cs_n       (adc_cs_n),
        .adc_rd_n       (adc_rd_n),
        .mux_sel        (mux_sel),
        .adc_data_cap_1 (adc_data_cap_1),
        .adc_data_cap_2 (adc_data_cap_2),
        .adc_data_cap_3 (adc_data_cap_3),
        .adc_data_valid (adc_data_valid),
        .adc_timeout_err(adc_timeout_err)
    );

    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int bad   = 0;
    int proto_bad = 0;

    // ADC model controls (written by the main sequence only)
    int mode       = 0;     // 0 table, 1 ch0 ramp 100..103, 2 full scale, 3 random
    int busy_len   = 5;
    bit busy_rand  = 1'b0;
    bit force_busy = 1'b0;

    // ADC model state (written by the model only)
    int          busy_cnt = 0;
    int          busy_cur = 0;
    logic        convst_prev = 1'b0;
    logic        rd_prev     = 1'b1;
    int unsigned tot_cnt [3] = '{0, 0, 0};
    longint      tot_sum [3] = '{0, 0, 0};

    // Main-sequence reference state
    int unsigned snap_cnt [3] = '{0, 0, 0};
    longint      snap_sum [3] = '{0, 0, 0};
    longint      exp_cap  [3] = '{0, 0, 0};

    function automatic int unsigned table_code(input int ch);
        case (ch)
            0:       return 8192;
            1:       return 12000;
            default: return 16383;
        endcase
    endfunction

    // ---------------------------------------------------------------- ADC model
    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            busy_cnt    = 0;
            convst_prev = 1'b0;
            rd_prev     = 1'b1;
        end else begin
            if (adc_convst) begin
                if (!convst_prev) begin
                    case (mode)
                        1:       adc_db = 14'((mux_sel == 2'd0) ? 100 + (tot_cnt[0] % 4)
                                                                : table_code(int'(mux_sel)));
                        2:       adc_db = 14'd16383;
                        3:       adc_db = 14'($urandom_range(0, 16383));
                        default: adc_db = 14'(table_code(int'(mux_sel)));
                    endcase
                    busy_cur = busy_rand ? int'($urandom_range(0, 8)) : busy_len;
                end
                busy_cnt = busy_cur;
            end else if (busy_cnt > 0) begin
                busy_cnt--;
            end
            // Second low read cycle: the DUT latches adc_db on the next edge.
            if (!adc_rd_n && !rd_prev) begin
                tot_sum[mux_sel] += longint'(adc_db);
                tot_cnt[mux_sel]++;
            end
            convst_prev = adc_convst;
            rd_prev     = adc_rd_n;
        end
        adc_busy = force_busy || (busy_cnt > 0);
    end

    // ---------------------------------------------------------- strobe monitor
    int       cv_run = 0;
    int       rd_run = 0;
    bit       in_conv = 1'b0;
    logic [1:0] mux_prev = 2'd0;

    always @(negedge sys_clk) begin
        if (!sys_rst_n) begin
            cv_run = 0; rd_run = 0; in_conv = 1'b0; mux_prev = 2'd0;
        end else begin
            if (adc_convst) cv_run++;
            else begin
                if (cv_run != 0 && cv_run != 2) proto_bad++;
                cv_run = 0;
            end
            if (!adc_rd_n) rd_run++;
            else begin
                if (rd_run != 0) begin
                    if (rd_run != 2) proto_bad++;
                    in_conv = 1'b0;
                end
                rd_run = 0;
            end
            if (adc_cs_n !== adc_rd_n) proto_bad++;
            if (adc_convst && !adc_cs_n) proto_bad++;
            if (mux_sel == 2'd3) proto_bad++;
            if (mux_sel != mux_prev) begin
                if (in_conv && !force_busy) proto_bad++;
                in_conv = 1'b0;
            end
            if (adc_convst) in_conv = 1'b1;
            mux_prev = mux_sel;
        end
    end

    // ------------------------------------------------------------------ helpers
    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic snapshot();
        for (int ch = 0; ch < 3; ch++) begin
            snap_cnt[ch] = tot_cnt[ch];
            snap_sum[ch] = tot_sum[ch];
        end
    endtask

    task automatic wait_valid(output bit found, output int n);
        found = 1'b0;
        n     = 0;
        for (int i = 1; i <= 2000; i++) begin
            @(negedge sys_clk);
            if (adc_data_valid) begin
                found = 1'b1;
                n     = i;
                break;
            end
        end
    endtask

    task automatic wait_mux(input logic [1:0] m);
        bit found = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (mux_sel == m) begin found = 1'b1; break; end
            @(negedge sys_clk);
        end
        chk($sformatf("mux_reach_%0d", m), found, 1);
    endtask

    // Waits for the end of a round, then checks every channel against the
    // mean of the codes the model served to that channel during the round.
    task automatic do_round(input bit to_ch1, input int exp_err, output int n);
        bit     found;
        int     dn;
        longint ds;
        wait_valid(found, n);
        chk("valid_seen", found, 1);
        for (int ch = 0; ch < 3; ch++) begin
            dn = int'(tot_cnt[ch] - snap_cnt[ch]);
            ds = tot_sum[ch] - snap_sum[ch];
            chk($sformatf("samples_ch%0d", ch), dn, (to_ch1 && ch == 1) ? 0 : NSAMP);
            if (dn == NSAMP) exp_cap[ch] = ds / NSAMP;
        end
        snapshot();
        chk("cap_1", adc_data_cap_1, exp_cap[0]);
        chk("cap_2", adc_data_cap_2, exp_cap[1]);
        chk("cap_3", adc_data_cap_3, exp_cap[2]);
        chk("timeout_err", adc_timeout_err, exp_err);
        @(negedge sys_clk);
        chk("valid_width", adc_data_valid, 0);
    endtask

    // ------------------------------------------------------------ main sequence
    initial begin
        int  n;
        int  k;
        bit  found;

        repeat (3) @(negedge sys_clk);
        chk("rst_convst", adc_convst, 0);
        chk("rst_cs_n", adc_cs_n, 1);
        chk("rst_rd_n", adc_rd_n, 1);
        chk("rst_mux", mux_sel, 0);
        chk("rst_cap_1", adc_data_cap_1, 0);
        chk("rst_cap_2", adc_data_cap_2, 0);
        chk("rst_cap_3", adc_data_cap_3, 0);
        chk("rst_valid", adc_data_valid, 0);
        chk("rst_err", adc_timeout_err, 0);
        sys_rst_n = 1'b1;
        snapshot();

        // Nominal rounds with the fixed code table
        do_round(1'b0, 0, n);
        do_round(1'b0, 0, n);
        // valid_width already consumed one cycle after the previous pulse
        chk("round_period", n, 3 * CHAN_NOM - 1);
        chk("nom_cap_1", adc_data_cap_1, 8192);
        chk("nom_cap_2", adc_data_cap_2, 12000);
        chk("nom_cap_3", adc_data_cap_3, 16383);

        // Averaging with truncation: 100..103 -> 406 >> 2 = 101
        mode = 1;
        do_round(1'b0, 0, n);
        chk("avg_trunc", adc_data_cap_1, 101);

        // Full scale on every channel
        mode = 2;
        do_round(1'b0, 0, n);
        chk("fs_cap_1", adc_data_cap_1, 16383);
        chk("fs_cap_2", adc_data_cap_2, 16383);
        chk("fs_cap_3", adc_data_cap_3, 16383);

        // Random codes and random busy widths
        mode      = 3;
        busy_rand = 1'b1;
        for (int r = 0; r < 4; r++) do_round(1'b0, 0, n);

        // Busy stuck low
        busy_rand = 1'b0;
        busy_len  = 0;
        do_round(1'b0, 0, n);

        // Busy stuck high on channel 1
        mode     = 0;
        busy_len = 5;
        wait_mux(2'd1);
        force_busy = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (adc_convst) begin found = 1'b1; break; end
            @(negedge sys_clk);
        end
        chk("to_convst_seen", found, 1);
        while (adc_convst) @(negedge sys_clk);
        // Now in the first WAIT_BUSY cycle (k = 1); the flag rises on the
        // edge that closes the 16th, so it is first seen in cycle 17.
        k = 0;
        for (int i = 1; i <= 100; i++) begin
            if (adc_timeout_err) begin k = i; break; end
            @(negedge sys_clk);
        end
        chk("to_latency", k, BUSY_TIMEOUT + 1);
        chk("to_mux_hold", mux_sel, 1);
        @(negedge sys_clk);
        chk("to_mux_adv", mux_sel, 2);
        repeat (2) @(negedge sys_clk);
        force_busy = 1'b0;
        do_round(1'b1, 1, n);
        do_round(1'b0, 1, n);

        // Reset asserted during READ
        found = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge sys_clk);
            if (!adc_cs_n) begin found = 1'b1; break; end
        end
        chk("rd_seen", found, 1);
        #1 sys_rst_n = 1'b0;
        #1;
        chk("mid_rst_cs_n", adc_cs_n, 1);
        chk("mid_rst_rd_n", adc_rd_n, 1);
        chk("mid_rst_convst", adc_convst, 0);
        chk("mid_rst_mux", mux_sel, 0);
        chk("mid_rst_caps", {adc_data_cap_1, adc_data_cap_2, adc_data_cap_3}, 0);
        chk("mid_rst_valid", adc_data_valid, 0);
        chk("mid_rst_err", adc_timeout_err, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        snapshot();
        exp_cap = '{0, 0, 0};
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge sys_clk);
            if (adc_data_cap_1 != 14'd0) begin n = i; break; end
        end
        chk("rst_first_pub", n, CHAN_NOM);
        do_round(1'b0, 0, n);

        chk("protocol", proto_bad, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_cap_acq.md
# adc_cap_acq

Acquisition front end for the capacitor-voltage measurement path. It drives one multiplexed 14-bit parallel ADC across three channels: resonant cap 1, resonant cap 2 and support cap. It averages 2^AVG_LOG2 conversions per channel and publishes one settled 14-bit code per channel. The outputs feed the capacitor-voltage scaling and threshold stage directly (`adc_data_cap_1..3`), so that stage always sees stable, filtered codes.

## Interface
- SETTLE_CYC, 50: cycles waited after every mux change before the first conversion.
- AVG_LOG2, 3: log2 of the number of samples averaged per channel. Legal range 0..4.
- BUSY_TIMEOUT, 200: cycles counted in WAIT_BUSY before a conversion is declared failed.
- sys_clk  in  1  system clock.
- sys_rst_n  in  1  reset, asynchronous assert, active-low.
- adc_busy  in  1  ADC conversion-in-progress, high while converting.
- adc_db  in  14  ADC parallel data, straight binary.
- adc_convst  out  1  conversion start, active-high.
- adc_cs_n  out  1  ADC chip select, active-low.
- adc_rd_n  out  1  ADC read strobe, active-low.
- mux_sel  out  2  analog mux select: 0 = cap 1, 1 = cap 2, 2 = support cap. Value 3 is never driven.
- adc_data_cap_1  out  14  averaged code, resonant cap 1.
- adc_data_cap_2  out  14  averaged code, resonant cap 2.
- adc_data_cap_3  out  14  averaged code, support cap.
- adc_data_valid  out  1  one-cycle pulse when a full 3-channel round completes.
- adc_timeout_err  out  1  sticky; set on any busy timeout, cleared only by reset.

## Operation
- Reset values:
  - convst = 0, cs_n = 1, rd_n = 1, mux_sel = 0.
  - All adc_data_cap_* = 0, valid = 0, timeout_err = 0.
  - Accumulator, sample counter and cycle counter = 0; FSM = SETTLE.
- FSM states:
  - SETTLE: count SETTLE_CYC cycles, then go to CONV.
  - CONV: convst high for exactly 2 cycles, then go to WAIT_BUSY.
  - WAIT_BUSY: leave for READ when adc_busy = 0 and at least 2 cycles have elapsed in the state. Go to TIMEOUT if the cycle count reaches BUSY_TIMEOUT.
  - READ: cs_n and rd_n low for 2 cycles. adc_db is registered on the clock edge that ends the second cycle; both strobes return high on that edge.
  - ACC: accumulator += sample; sample counter +1.
    - If the counter has not reached 2^AVG_LOG2, go to CONV.
    - Otherwise publish the channel, clear the accumulator and counter, advance mux_sel, and go to SETTLE.
  - TIMEOUT (1 cycle): set timeout_err, discard the accumulator and counter for the current channel, leave that channel's output unchanged, advance mux_sel, and go to SETTLE.
- Channel advance: 0→1→2→0 wrap.
- Round completion: the advance out of channel 2 ends a round. valid pulses on that advance whether channel 2 published or timed out.
- Arithmetic:
  - Accumulator width is 14+AVG_LOG2 bits. Full scale (16383 × 2^AVG_LOG2) never overflows.
  - Published code = accumulator >> AVG_LOG2, truncated, not rounded.
- adc_db is passed through with no offset or scaling; the downstream stage owns the conversion to mV.
- The sequencer free-runs from reset. There is no enable input.

## Timing
- One sample costs 2 (CONV) + W (WAIT_BUSY, W ≥ 2) + 2 (READ) + 1 (ACC) cycles.
- One channel costs SETTLE_CYC + 2^AVG_LOG2 × sample cycles + 1.
- Publish and valid:
  - The published adc_data_cap_n updates on the clock edge that ends the final ACC cycle.
  - adc_data_valid is high for exactly the cycle after that edge, coincident with the new adc_data_cap_3.
  - In the timeout case, valid instead aligns with the TIMEOUT exit edge.
- mux_sel changes on the same edge that enters SETTLE. It never changes during CONV, WAIT_BUSY or READ.
- adc_busy and adc_db are used as registered, single-clock-domain signals. The ADC is clocked from sys_clk, so no synchronizer is required.
- Reset asserted mid-operation (any state): all outputs take their reset values immediately and the FSM restarts at SETTLE on channel 0. Partial accumulations are lost.
- adc_busy stuck low: the FSM still waits the 2-cycle minimum, then reads. No error is flagged.

## Test plan
- Nominal round:
  - Settings: SETTLE_CYC = 4, AVG_LOG2 = 2, BUSY_TIMEOUT = 16.
  - ADC model: busy high for 5 cycles after convst; returns 8192 / 12000 / 16383 for mux 0 / 1 / 2.
  - Required: adc_data_cap_1..3 = 8192 / 12000 / 16383; valid pulses once per round, width 1; timeout_err stays 0.
- Averaging/truncation: samples 100, 101, 102, 103 on channel 0 → adc_data_cap_1 = 101 (406 >> 2).
- Full scale: 16383 four times → accumulator 65532 → output 16383, no wrap.
- Timeout:
  - Stimulus: busy held high on channel 1.
  - Required:
    - timeout_err rises 16 cycles into WAIT_BUSY and stays set.
    - adc_data_cap_2 keeps its previous value.
    - mux_sel moves to 2.
    - The next round completes normally with timeout_err still 1.
- Reset mid-READ: deassert sys_rst_n while cs_n is low → cs_n = rd_n = 1, convst = 0, mux_sel = 0 and all outputs = 0 at once. After release, first publish is SETTLE_CYC + 4 × sample cycles + 1 later.
- Strobe protocol check:
  - convst is 2 cycles wide.
  - cs_n/rd_n are 2 cycles wide and never overlap convst.
  - mux_sel is stable from SETTLE entry through the last READ of the channel.
